// File: rtl/sobel_edge_if.sv
// ---------------------------------------------------------------------------
// sobel_edge_if
// Pixel stream bundle between the grayscale stage, the Sobel edge detector
// and the display/post-processing path.
//   i_start : one-cycle frame-start pulse
//   i_valid : input pixel qualifier
//   i_gray  : 10-bit unsigned gray pixel
//   o_valid : one pulse per accepted input pixel
//   o_mag   : saturated gradient magnitude
//   o_edge  : edge flag
//   o_busy  : high while a frame is being received
// Modports: slave = detector side, master = pixel source / result sink side.
// ---------------------------------------------------------------------------
interface sobel_edge_if;
  logic       i_start;
  logic       i_valid;
  logic [9:0] i_gray;
  logic       o_valid;
  logic [9:0] o_mag;
  logic       o_edge;
  logic       o_busy;

  modport slave (
    input  i_start, i_valid, i_gray,
    output o_valid, o_mag, o_edge, o_busy
  );

  modport master (
    output i_start, i_valid, i_gray,
    input  o_valid, o_mag, o_edge, o_busy
  );
endinterface

// File: rtl/sobel_edge.sv
// ---------------------------------------------------------------------------
// sobel_edge
// Streaming 3x3 Sobel edge detector. Consumes raster-order gray pixels,
// keeps the two previous rows in line buffers and emits one saturated
// gradient magnitude (|Gx|+|Gy|, capped at 1023) per accepted pixel, two
// cycles after acceptance. The 3x3 window ends at the current pixel, so the
// result for pixel (r,c) is centred on (r-1,c-1). Results with r<2 or c<2
// are forced to zero.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : sobel_edge_if.slave (start/valid/gray in, valid/mag/edge/busy out)
// Parameters: WIDTH (pixels/row), HEIGHT (rows/frame), THRESHOLD (edge level).
// Optional feature macro: SOBEL_EDGE_FLAG_EN enables the registered edge
// flag (o_mag > THRESHOLD); when undefined o_edge is constant low.
// ---------------------------------------------------------------------------
module sobel_edge #(
  parameter int WIDTH     = 640,
  parameter int HEIGHT    = 480,
  parameter int THRESHOLD = 256
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  sobel_edge_if.slave bus
);
  localparam int COL_W = (WIDTH  > 2) ? $clog2(WIDTH)  : 2;
  localparam int ROW_W = (HEIGHT > 2) ? $clog2(HEIGHT) : 2;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t             state;
  logic               busy;
  logic [COL_W-1:0]   col;
  logic [ROW_W-1:0]   row;
  logic               accept;
  logic               last_col;
  logic               last_px;

  // A start in the same cycle as a valid pixel wins; that pixel is dropped.
  assign accept   = (state == S_RUN) && bus.i_valid && !bus.i_start;
  assign last_col = (col == COL_W'(WIDTH - 1));
  assign last_px  = last_col && (row == ROW_W'(HEIGHT - 1));
  assign bus.o_busy = busy;

  // Frame FSM and raster counters.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      col   <= '0;
      row   <= '0;
    end else if (bus.i_start) begin
      state <= S_RUN;
      busy  <= 1'b1;
      col   <= '0;
      row   <= '0;
    end else if (accept) begin
      if (last_px) begin
        state <= S_IDLE;
        busy  <= 1'b0;
        col   <= '0;
      end else if (last_col) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Line buffers: lb0 holds the previous row, lb1 the row before it.
  // Reads are registered and return the pre-write contents.
  logic [9:0] lb0 [WIDTH];
  logic [9:0] lb1 [WIDTH];
  logic [9:0] top_rd;
  logic [9:0] mid_rd;
  logic [9:0] cur_rd;

  always_ff @(posedge i_clk) begin
    if (accept) begin
      lb0[col] <= bus.i_gray;
      lb1[col] <= lb0[col];
      top_rd   <= lb1[col];
      mid_rd   <= lb0[col];
      cur_rd   <= bus.i_gray;
    end
  end

  // Stage 1: window shift. win[row][col], row 0 = two rows up,
  // col 2 = newest column. Idle cycles freeze the window.
  logic [9:0] win [3][3];
  logic       v0, v1;
  logic       border0, border1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v0      <= 1'b0;
      v1      <= 1'b0;
      border0 <= 1'b0;
      border1 <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win[r][c] <= '0;
        end
      end
    end else begin
      v0 <= accept;
      v1 <= v0;
      if (accept) begin
        border0 <= (row < ROW_W'(2)) || (col < COL_W'(2));
      end
      if (v0) begin
        border1 <= border0;
        for (int r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
        end
        win[0][2] <= top_rd;
        win[1][2] <= mid_rd;
        win[2][2] <= cur_rd;
      end
    end
  end

  // Stage 2: gradient. Each weighted column/row sum is at most 4*1023, so
  // 13-bit signed holds the differences without overflow.
  function automatic logic signed [12:0] ext(input logic [9:0] p);
    return $signed({3'b000, p});
  endfunction

  logic signed [12:0] gx, gy;
  logic        [12:0] ax, ay, sum;
  logic        [9:0]  mag_next;

  always_comb begin
    gx = (ext(win[0][2]) + (ext(win[1][2]) <<< 1) + ext(win[2][2]))
       - (ext(win[0][0]) + (ext(win[1][0]) <<< 1) + ext(win[2][0]));
    gy = (ext(win[2][0]) + (ext(win[2][1]) <<< 1) + ext(win[2][2]))
       - (ext(win[0][0]) + (ext(win[0][1]) <<< 1) + ext(win[0][2]));
    ax = gx[12] ? 13'(-gx) : 13'(gx);
    ay = gy[12] ? 13'(-gy) : 13'(gy);
    sum = ax + ay;
    mag_next = (sum > 13'd1023) ? 10'd1023 : sum[9:0];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bus.o_valid <= 1'b0;
      bus.o_mag   <= '0;
    end else begin
      bus.o_valid <= v1;
      if (v1) begin
        bus.o_mag <= border1 ? 10'd0 : mag_next;
      end
    end
  end

`ifdef SOBEL_EDGE_FLAG_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bus.o_edge <= 1'b0;
    end else if (v1) begin
      bus.o_edge <= !border1 && (int'(mag_next) > THRESHOLD);
    end
  end
`else
  // Flag disabled: constant low for any non-negative THRESHOLD.
  assign bus.o_edge = (THRESHOLD < 0);
`endif

endmodule

// File: tb/tb_sobel_edge.sv
// ---------------------------------------------------------------------------
// tb_sobel_edge
// Self-checking bench for sobel_edge on a reduced 16x8 frame. Expected
// results are computed from a bench-side image copy when a pixel is driven,
// queued with their due cycle and compared when o_valid appears.
// ---------------------------------------------------------------------------
module tb_sobel_edge;
  localparam int W  = 16;
  localparam int H  = 8;
  localparam int TH = 256;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sobel_edge_if bus ();

  sobel_edge #(.WIDTH(W), .HEIGHT(H), .THRESHOLD(TH)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  typedef struct {
    int mag;
    int edge_f;
    int due;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   n_out    = 0;
  int   img [H][W];
  bit   run_m    = 1'b0;
  int   rm       = 0;
  int   cm       = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Reference: 3x3 window with bottom-right at (r,c).
  function automatic int ref_mag(input int r, input int c);
    int gx, gy, s;
    if (r < 2 || c < 2) return 0;
    gx = (img[r-2][c] + 2*img[r-1][c] + img[r][c])
       - (img[r-2][c-2] + 2*img[r-1][c-2] + img[r][c-2]);
    gy = (img[r][c-2] + 2*img[r][c-1] + img[r][c])
       - (img[r-2][c-2] + 2*img[r-2][c-1] + img[r-2][c]);
    s = iabs(gx) + iabs(gy);
    return (s > 1023) ? 1023 : s;
  endfunction

  function automatic int edge_exp(input int m);
`ifdef SOBEL_EDGE_FLAG_EN
    return (m > TH) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  function automatic int pix(input int pat, input int r, input int c);
    case (pat)
      0:       return 300;
      1:       return (c >= W/2) ? 1023 : 0;
      2:       return 10 * c;
      default: return int'($urandom_range(0, 1023)) + 0 * r;
    endcase
  endfunction

  // Output monitor: pops one expectation per o_valid pulse, checks value
  // and arrival cycle; an overdue expectation counts as a missing pulse.
  always @(negedge clk) begin : mon
    exp_t e;
    if (bus.o_valid) begin
      n_out++;
      if (sbq.size() == 0) begin
        check_eq("unexpected_valid", 1, 0);
      end else begin
        e = sbq.pop_front();
        check_eq("mag", int'(bus.o_mag), e.mag);
        check_eq("edge", int'(bus.o_edge), e.edge_f);
        check_eq("latency", cyc, e.due);
      end
    end else if (sbq.size() > 0 && sbq[0].due < cyc) begin
      void'(sbq.pop_front());
      check_eq("missing_valid", 0, 1);
    end
  end

  // One input cycle: drive after the falling edge, update the model.
  task automatic step(input bit s, input bit v, input int g);
    int m;
    @(negedge clk);
    check_eq("busy", int'(bus.o_busy), int'(run_m));
    bus.i_start = s;
    bus.i_valid = v;
    bus.i_gray  = 10'(g);
    if (s) begin
      run_m = 1'b1;
      rm = 0;
      cm = 0;
    end else if (run_m && v) begin
      img[rm][cm] = g;
      m = ref_mag(rm, cm);
      sbq.push_back('{mag: m, edge_f: edge_exp(m), due: cyc + 3});
      if (cm == W-1) begin
        cm = 0;
        if (rm == H-1) run_m = 1'b0;
        else rm++;
      end else begin
        cm++;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, int'($urandom_range(0, 1023)));
  endtask

  // Start pulse (optionally with a valid pixel that must be dropped), then
  // rows 0..stop_row-1; gap inserts an idle cycle every third cycle.
  task automatic run_frame(input int pat, input bit gap, input int stop_row,
                           input bit start_valid);
    int k = 0;
    step(1'b1, start_valid, 777);
    for (int r = 0; r < stop_row; r++) begin
      for (int c = 0; c < W; c++) begin
        if (gap && (k % 3) == 2) begin
          step(1'b0, 1'b0, int'($urandom_range(0, 1023)));
          k++;
        end
        step(1'b0, 1'b1, pix(pat, r, c));
        k++;
      end
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    sbq.delete();
    run_m = 1'b0;
    @(negedge clk);
    check_eq("rst_valid", int'(bus.o_valid), 0);
    check_eq("rst_mag", int'(bus.o_mag), 0);
    check_eq("rst_edge", int'(bus.o_edge), 0);
    check_eq("rst_busy", int'(bus.o_busy), 0);
    rst_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int o0;
    bus.i_start = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_gray  = '0;
    repeat (3) @(negedge clk);
    check_eq("reset_valid", int'(bus.o_valid), 0);
    check_eq("reset_mag", int'(bus.o_mag), 0);
    check_eq("reset_edge", int'(bus.o_edge), 0);
    check_eq("reset_busy", int'(bus.o_busy), 0);
    rst_n = 1'b1;

    // Valid pixels while idle produce nothing.
    repeat (5) step(1'b0, 1'b1, 500);
    idle(4);

    // Flat frame: every result zero, one pulse per pixel.
    o0 = n_out;
    run_frame(0, 1'b0, H, 1'b0);
    idle(4);
    check_eq("flat_count", n_out - o0, W*H);

    // Vertical step, consecutive then gapped.
    run_frame(1, 1'b0, H, 1'b0);
    idle(4);
    o0 = n_out;
    run_frame(1, 1'b1, H, 1'b0);
    idle(4);
    check_eq("gap_count", n_out - o0, W*H);

    // Gradient frame started with a valid pixel on the start cycle.
    run_frame(2, 1'b0, H, 1'b1);
    idle(4);

    // Mid-frame restart at row 4, followed by a full gradient frame.
    run_frame(3, 1'b0, 4, 1'b0);
    run_frame(2, 1'b0, H, 1'b0);
    idle(4);

    // Reset at row 5, idle pixels ignored, then a full random frame.
    run_frame(3, 1'b0, 5, 1'b0);
    pulse_reset();
    repeat (5) step(1'b0, 1'b1, 123);
    run_frame(3, 1'b0, H, 1'b0);
    idle(6);

    check_eq("scoreboard_empty", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
